ab_seq_gen: RTL and testbench

- Hardware stimulus sequencer that drives the 2-bit input pair (a, b) of the circuit1/circuit2 stage.
- On `start`, it steps through the four combinations 00, 01, 10, 11. Each step is held for a programmable number of clock cycles, and the last step is held longer so the clocked stage can settle.
- It replaces hand-written stimulus so the downstream stage can be exercised in-system. It reports progress through busy, done and step-strobe outputs.

---
 rtl/ab_seq_gen_pkg.sv | 16 +
 rtl/ab_seq_gen_hold_timer.sv | 25 ++
 rtl/ab_seq_gen.sv | 117 +++++++++++
 tb/tb_ab_seq_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ab_seq_gen_pkg.sv
// Shared encodings for the (a, b) stimulus sequencer.
package ab_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_00   = 2'd0;
  localparam logic [1:0] STEP_01   = 2'd1;
  localparam logic [1:0] STEP_10   = 2'd2;
  localparam logic [1:0] STEP_11   = 2'd3;
  localparam logic [1:0] LAST_STEP = 2'd3;

endpackage

// File: rtl/ab_seq_gen_hold_timer.sv
// Hold counter for one sequencer step; last flags the final cycle of a step of length len.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] len_m1;

  assign len_m1 = len - CNT_W'(1);
  assign last   = (cnt == len_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ab_seq_gen.sv
// Steps (a, b) through 00, 01, 10, 11 with programmable per-step hold; all outputs registered.
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int HOLD_CYCLES      = 5,
  parameter int LAST_HOLD_CYCLES = 10,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       loop_en,
  input  logic       pause,
  output logic       a,
  output logic       b,
  output logic [1:0] step_idx,
  output logic       step_strobe,
  output logic       busy,
  output logic       done
);

  localparam longint MAX_HOLD = (64'd1 << CNT_W) - 64'd1;

  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > MAX_HOLD) begin : g_bad_hold
    $error("ab_seq_gen: HOLD_CYCLES out of range for CNT_W");
  end
  if (LAST_HOLD_CYCLES < 1 || longint'(LAST_HOLD_CYCLES) > MAX_HOLD) begin : g_bad_last
    $error("ab_seq_gen: LAST_HOLD_CYCLES out of range for CNT_W");
  end

  state_t           state_q, state_d;
  logic [1:0]       step_d;
  logic             strobe_d, busy_d, done_d, a_d, b_d;
  logic [CNT_W-1:0] len, hold_cnt;
  logic             last, run_go, advance, clr;
  logic             unused_cnt;

  assign len     = (step_idx == LAST_STEP) ? CNT_W'(LAST_HOLD_CYCLES) : CNT_W'(HOLD_CYCLES);
  assign run_go  = (state_q == ST_RUN) && !pause;
  assign advance = run_go && last;
  // Counter is held at zero outside RUN so every step starts from a clean count.
  assign clr     = (state_q != ST_RUN) || advance;
  assign unused_cnt = ^hold_cnt;

  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (run_go),
    .len   (len),
    .cnt   (hold_cnt),
    .last  (last)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_idx;
    strobe_d = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_RUN;
        step_d   = STEP_00;
        strobe_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_RUN: if (advance) begin
        if (step_idx != LAST_STEP) begin
          step_d   = step_idx + 2'd1;
          strobe_d = 1'b1;
        end else if (loop_en) begin
          step_d   = STEP_00;
          strobe_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          step_d  = STEP_00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = STEP_00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = STEP_00;
        busy_d  = 1'b0;
      end
    endcase
    a_d = busy_d & step_d[1];
    b_d = busy_d & step_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_idx    <= STEP_00;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_idx    <= step_d;
      step_strobe <= strobe_d;
      busy        <= busy_d;
      done        <= done_d;
      a           <= a_d;
      b           <= b_d;
    end
  end

endmodule

// File: tb/tb_ab_seq_gen.sv
// Directed bench for ab_seq_gen: default timing, pause, loop, async reset, held start, 1-cycle corner.
module tb_ab_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, loop_en, pause;
  logic       a, b, step_strobe, busy, done;
  logic [1:0] step_idx;
  logic       start_c;
  logic       a_c, b_c, strobe_c, busy_c, done_c;
  logic [1:0] step_c;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  ab_seq_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en), .pause(pause),
    .a(a), .b(b), .step_idx(step_idx), .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  ab_seq_gen #(.HOLD_CYCLES(1), .LAST_HOLD_CYCLES(1), .CNT_W(8)) u_corner (
    .clk(clk), .rst_n(rst_n), .start(start_c), .loop_en(1'b0), .pause(1'b0),
    .a(a_c), .b(b_c), .step_idx(step_c), .step_strobe(strobe_c), .busy(busy_c), .done(done_c)
  );

  wire [6:0] obs   = {a, b, step_idx, step_strobe, busy, done};
  wire [6:0] obs_c = {a_c, b_c, step_c, strobe_c, busy_c, done_c};

  // {a, b, step_idx, step_strobe, busy, done}
  function automatic logic [6:0] ev(input logic bz, input logic [1:0] st, input logic sb, input logic dn);
    return {bz & st[1], bz & st[0], st, sb, bz, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; loop_en = 0; pause = 0; start_c = 0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL reset got %b exp %b", obs, 7'd0); end
    n_tests++;
    if (obs_c !== 7'd0) begin n_fail++; $display("FAIL reset_corner got %b exp %b", obs_c, 7'd0); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL reset_idle got %b exp %b", obs, 7'd0); end
  endtask

  task automatic test_basic();
    logic [6:0] exp;
    logic [1:0] st;
    start = 1'b1;
    for (int e = 0; e <= 26; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      st  = (e < 5) ? 2'd0 : (e < 10) ? 2'd1 : (e < 15) ? 2'd2 : 2'd3;
      exp = (e <= 24) ? ev(1'b1, st, (e == 0 || e == 5 || e == 10 || e == 15), 1'b0)
                      : ev(1'b0, 2'd0, 1'b0, e == 25);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL basic e=%0d got %b exp %b", e, obs, exp); end
    end
  endtask

  task automatic test_pause();
    logic [6:0] exp;
    logic [1:0] st;
    start = 1'b1;
    for (int e = 0; e <= 29; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      if (e == 6) pause = 1'b1;
      if (e == 9) pause = 1'b0;
      st  = (e < 5) ? 2'd0 : (e < 13) ? 2'd1 : (e < 18) ? 2'd2 : 2'd3;
      exp = (e <= 27) ? ev(1'b1, st, (e == 0 || e == 5 || e == 13 || e == 18), 1'b0)
                      : ev(1'b0, 2'd0, 1'b0, e == 28);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL pause e=%0d got %b exp %b", e, obs, exp); end
    end
  endtask

  task automatic test_loop();
    logic [6:0] exp;
    logic [1:0] st;
    int         p;
    loop_en = 1'b1;
    start   = 1'b1;
    for (int e = 0; e <= 51; e++) begin
      tick();
      if (e == 0)  start = 1'b0;
      if (e == 49) loop_en = 1'b0;
      p   = e % 25;
      st  = (p < 5) ? 2'd0 : (p < 10) ? 2'd1 : (p < 15) ? 2'd2 : 2'd3;
      exp = (e < 50) ? ev(1'b1, st, (p == 0 || p == 5 || p == 10 || p == 15), 1'b0)
                     : ev(1'b0, 2'd0, 1'b0, e == 50);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL loop e=%0d got %b exp %b", e, obs, exp); end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    n_tests++;
    if (obs !== ev(1'b1, 2'd2, 1'b0, 1'b0))
      begin n_fail++; $display("FAIL arst_pre got %b exp %b", obs, ev(1'b1, 2'd2, 1'b0, 1'b0)); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL arst_immediate got %b exp %b", obs, 7'd0); end
    tick();
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL arst_held got %b exp %b", obs, 7'd0); end
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (obs !== ev(1'b1, 2'd0, 1'b1, 1'b0))
      begin n_fail++; $display("FAIL arst_restart got %b exp %b", obs, ev(1'b1, 2'd0, 1'b1, 1'b0)); end
    repeat (5) tick();
    n_tests++;
    if (obs !== ev(1'b1, 2'd1, 1'b1, 1'b0))
      begin n_fail++; $display("FAIL arst_step1 got %b exp %b", obs, ev(1'b1, 2'd1, 1'b1, 1'b0)); end
    repeat (21) tick();
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL arst_idle got %b exp %b", obs, 7'd0); end
  endtask

  task automatic test_start_held();
    logic [6:0] exp;
    logic [1:0] st;
    start = 1'b1;
    for (int e = 0; e <= 27; e++) begin
      tick();
      st = (e < 5) ? 2'd0 : (e < 10) ? 2'd1 : (e < 15) ? 2'd2 : 2'd3;
      if (e <= 24)      exp = ev(1'b1, st, (e == 0 || e == 5 || e == 10 || e == 15), 1'b0);
      else if (e == 27) exp = ev(1'b1, 2'd0, 1'b1, 1'b0);
      else              exp = ev(1'b0, 2'd0, 1'b0, e == 25);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL start_held e=%0d got %b exp %b", e, obs, exp); end
    end
    start = 1'b0;
    repeat (26) tick();
    n_tests++;
    if (obs !== 7'd0) begin n_fail++; $display("FAIL start_held_idle got %b exp %b", obs_c, 7'd0); end
  endtask

  task automatic test_corner();
    logic [6:0] exp;
    start_c = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 0) start_c = 1'b0;
      exp = (e <= 3) ? ev(1'b1, 2'(e), 1'b1, 1'b0) : ev(1'b0, 2'd0, 1'b0, e == 4);
      n_tests++;
      if (obs_c !== exp) begin n_fail++; $display("FAIL corner e=%0d got %b exp %b", e, obs_c, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_loop();
    test_async_reset();
    test_start_held();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
